// File: rtl/piso_stream.sv
`default_nettype none
// ============================================================================
// Module      : piso_stream
// Description : Parametrised parallel-in/serial-out shifter with a load
//               handshake, back-to-back word support, shift-enable pacing
//               and valid/last framing on the serial side.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_stream #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] p_in,
  output logic             p_ready,
  input  logic             shift_en,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_last,
  output logic             busy
);

  // Counter holds the number of bits still to come after the current one.
  localparam int                 c_cnt_w    = $clog2(WIDTH) + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_sreg;
  logic [WIDTH-1:0]   w_sreg_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               w_shifting;
  logic               w_last;
  logic               w_ready;
  logic               w_accept;
  logic               w_out_bit;

  // Output-end bit of the shift register; s_out only ever sees registers.
  assign w_out_bit = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers: shift register and bits-remaining counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else begin
      r_sreg <= w_sreg_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  // Next-state, datapath update and output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_cnt_nxt   = r_cnt;

    w_shifting  = (r_state == S_SHIFT);
    w_last      = w_shifting && (r_cnt == '0);
    // Ready again on the edge that consumes the last bit, so the next word
    // follows without an idle bit.
    w_ready     = !w_shifting || (w_last && shift_en);
    w_accept    = load && w_ready;

    s_valid     = w_shifting;
    busy        = w_shifting;
    s_last      = w_last;
    p_ready     = w_ready;
    s_out       = w_shifting ? w_out_bit : IDLE_LEVEL;

    if (w_shifting && shift_en) begin
      if (w_last) begin
        w_state_nxt = S_IDLE;
      end else begin
        w_sreg_nxt = MSB_FIRST ? (r_sreg << 1) : (r_sreg >> 1);
        w_cnt_nxt  = r_cnt - c_cnt_one;
      end
    end

    // A new word overrides the return to idle on the last-bit edge.
    if (w_accept) begin
      w_state_nxt = S_SHIFT;
      w_sreg_nxt  = p_in;
      w_cnt_nxt   = c_cnt_load;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_stream
// Description : Self-checking bench for piso_stream. Four instances cover
//               8-bit MSB-first, 4-bit LSB-first, 1-bit and 4-bit MSB-first
//               configurations against a word/bit-index reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] load;
  logic [3:0] shift_en;
  logic [7:0] p_in0;
  logic [3:0] p_in1;
  logic [0:0] p_in2;
  logic [3:0] p_in3;
  logic [3:0] p_ready;
  logic [3:0] s_out;
  logic [3:0] s_valid;
  logic [3:0] s_last;
  logic [3:0] busy;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  piso_stream #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .load(load[0]), .p_in(p_in0), .p_ready(p_ready[0]),
    .shift_en(shift_en[0]), .s_out(s_out[0]), .s_valid(s_valid[0]),
    .s_last(s_last[0]), .busy(busy[0]));

  piso_stream #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .load(load[1]), .p_in(p_in1), .p_ready(p_ready[1]),
    .shift_en(shift_en[1]), .s_out(s_out[1]), .s_valid(s_valid[1]),
    .s_last(s_last[1]), .busy(busy[1]));

  piso_stream #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .load(load[2]), .p_in(p_in2), .p_ready(p_ready[2]),
    .shift_en(shift_en[2]), .s_out(s_out[2]), .s_valid(s_valid[2]),
    .s_last(s_last[2]), .busy(busy[2]));

  piso_stream #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut3 (
    .clk(clk), .rst(rst), .load(load[3]), .p_in(p_in3), .p_ready(p_ready[3]),
    .shift_en(shift_en[3]), .s_out(s_out[3]), .s_valid(s_valid[3]),
    .s_last(s_last[3]), .busy(busy[3]));

  // Per-instance configuration as seen by the model.
  function automatic int wid(int i);
    case (i)
      0:       return 8;
      1:       return 4;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic bit msbf(int i);
    return (i != 1);
  endfunction

  function automatic bit idle_lv(int i);
    return (i == 1) || (i == 2);
  endfunction

  function automatic logic [31:0] pin(int i);
    case (i)
      0:       return 32'(p_in0);
      1:       return 32'(p_in1);
      2:       return 32'(p_in2);
      default: return 32'(p_in3);
    endcase
  endfunction

  // Reference model: the accepted word plus the number of bits consumed.
  logic [31:0] m_word [4];
  int          m_k    [4];
  bit          m_act  [4];

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_word[i] = '0;
      m_k[i]    = 0;
      m_act[i]  = 1'b0;
    end
  end

  function automatic bit m_ready(int i);
    return !m_act[i] || ((m_k[i] == wid(i) - 1) && shift_en[i]);
  endfunction

  function automatic bit m_bit(int i);
    if (!m_act[i]) return idle_lv(i);
    return msbf(i) ? m_word[i][wid(i) - 1 - m_k[i]] : m_word[i][m_k[i]];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        m_act[i] <= 1'b0;
      end else if (load[i] && m_ready(i)) begin
        m_word[i] <= pin(i);
        m_k[i]    <= 0;
        m_act[i]  <= 1'b1;
      end else if (m_act[i] && shift_en[i]) begin
        if (m_k[i] == wid(i) - 1) m_act[i] <= 1'b0;
        else                      m_k[i]   <= m_k[i] + 1;
      end
    end
  end

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h at %0t", nm, idx, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 4; i++) begin
        chk("s_valid", i, 32'(s_valid[i]), 32'(m_act[i]));
        chk("busy",    i, 32'(busy[i]),    32'(m_act[i]));
        chk("s_last",  i, 32'(s_last[i]),  32'(m_act[i] && (m_k[i] == wid(i) - 1)));
        chk("p_ready", i, 32'(p_ready[i]), 32'(m_ready(i)));
        chk("s_out",   i, 32'(s_out[i]),   32'(m_bit(i)));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  cap0, cap3, last3, val3;
  logic [3:0]  cap1;
  logic [6:0]  bits7;
  logic [15:0] bits16;
  logic [17:0] val18;
  int          nv, nl;
  logic        orb, allv;
  bit          acc;

  initial begin
    // Reset with a load pending: nothing may be captured.
    rst = 1'b1; load = 4'hF; shift_en = 4'hF;
    p_in0 = '1; p_in1 = '1; p_in2 = '1; p_in3 = '1;
    step(); step();
    rst = 1'b0; load = 4'h0; chk_on = 1'b1;
    @(negedge clk);
    chk("rst_valid", -1, 32'(s_valid), 32'h0);
    chk("rst_ready", -1, 32'(p_ready), 32'hF);
    chk("rst_out",   -1, 32'(s_out),   32'h6);
    step();
    @(negedge clk);
    chk("rst_noword", -1, 32'(s_valid), 32'h0);
    step();

    // Bit order: A5 MSB-first, 1011 LSB-first, 1011 MSB-first.
    p_in0 = 8'hA5; p_in1 = 4'b1011; p_in3 = 4'b1011; load = 4'b1011;
    step();
    load = 4'h0;
    cap0 = '0; cap1 = '0; cap3 = '0; last3 = '0; val3 = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      cap0  = {cap0[6:0], s_out[0]};
      if (c < 4) cap1 = {cap1[2:0], s_out[1]};
      cap3  = {cap3[6:0], s_out[3]};
      last3 = {last3[6:0], s_last[3]};
      val3  = {val3[6:0], s_valid[3]};
      step();
    end
    chk("order_msb8",  0, 32'(cap0),  32'hA5);
    chk("order_lsb4",  1, 32'(cap1),  32'hD);
    chk("order_msb4",  3, 32'(cap3),  32'hB0);
    chk("last_msb4",   3, 32'(last3), 32'h10);
    chk("valid_msb4",  3, 32'(val3),  32'hF0);

    // Stall for 3 cycles on the second bit.
    p_in3 = 4'b1011; load[3] = 1'b1;
    step();
    load[3] = 1'b0; nv = 0; bits7 = '0;
    for (int c = 0; c < 9; c++) begin
      shift_en[3] = !((c >= 1) && (c <= 3));
      @(negedge clk);
      if (s_valid[3]) begin
        nv++;
        bits7 = {bits7[5:0], s_out[3]};
      end
      step();
    end
    shift_en = 4'hF;
    chk("stall_cycles", 3, 32'(nv),    32'd7);
    chk("stall_bits",   3, 32'(bits7), 32'h43);

    // Back-to-back words with load held.
    p_in0 = 8'hF0; load[0] = 1'b1;
    step();
    p_in0 = 8'h0F; bits16 = '0; val18 = '0; nl = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      val18 = {val18[16:0], s_valid[0]};
      if (s_valid[0]) bits16 = {bits16[14:0], s_out[0]};
      if (s_last[0]) nl++;
      acc = p_ready[0] && load[0];
      step();
      if (acc) load[0] = 1'b0;
    end
    chk("b2b_bits",  0, 32'(bits16), 32'hF00F);
    chk("b2b_valid", 0, 32'(val18),  32'h3FFFC);
    chk("b2b_lasts", 0, 32'(nl),     32'd2);

    // Load while busy is ignored; reset mid-word aborts.
    p_in0 = 8'h00; load[0] = 1'b1;
    step();
    load[0] = 1'b0; orb = 1'b0; allv = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin load[0] = 1'b1; p_in0 = 8'hFF; end
      if (c == 4) rst = 1'b1;
      @(negedge clk);
      orb  = orb | s_out[0];
      allv = allv & s_valid[0];
      step();
    end
    @(negedge clk);
    chk("busy_load_bits",  0, 32'(orb),        32'h0);
    chk("busy_load_valid", 0, 32'(allv),       32'h1);
    chk("abort_valid",     0, 32'(s_valid[0]), 32'h0);
    chk("abort_ready",     0, 32'(p_ready[0]), 32'h1);
    step();
    rst = 1'b0; load = 4'h0;
    step();

    // Randomised traffic, pacing and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 199) == 0);
      load     = 4'($urandom);
      shift_en = 4'($urandom) | 4'($urandom);
      p_in0    = 8'($urandom);
      p_in1    = 4'($urandom);
      p_in2    = 1'($urandom);
      p_in3    = 4'($urandom);
      step();
    end
    rst = 1'b0; load = 4'h0; shift_en = 4'hF;
    for (int c = 0; c < 12; c++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
